// File: rtl/switch_reader_pkg.sv
// Shared definitions for the switch/button input peripheral: register map
// and the board-clock debounce default.
package switch_reader_pkg;

    localparam logic [1:0] SW_ADDR_STATE = 2'd0;
    localparam logic [1:0] SW_ADDR_EDGE  = 2'd1;
    localparam logic [1:0] SW_ADDR_MASK  = 2'd2;

    localparam int SW_DEBOUNCE_DEFAULT = 1000000;

endpackage

// File: rtl/switch_reader_debounce_bit.sv
// One switch input: two-flop synchroniser, debounce counter and stable flop.
// o_rise pulses on the same edge that stable goes 0->1.
module debounce_bit
    import switch_reader_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = SW_DEBOUNCE_DEFAULT,
    parameter int CNT_W           = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic i_raw,
    output logic o_stable,
    output logic o_rise
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q;
    logic             stable_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Any agreement with the stable level restarts the count, so only an
    // unbroken run of DEBOUNCE_CYCLES differing samples moves stable.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            stable_d = sync2_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= i_raw;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign o_stable = stable_q;
    assign o_rise   = stable_d & ~stable_q;

endmodule

// File: rtl/switch_reader.sv
// Memory-mapped switch/button reader: debounced state, sticky read-to-clear
// rising-edge register, interrupt mask and a registered read port.
module switch_reader
    import switch_reader_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = SW_DEBOUNCE_DEFAULT,
    parameter int CNT_W           = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_switch,
    input  logic             i_rd_en,
    input  logic             i_wr_en,
    input  logic [1:0]       i_addr,
    input  logic [31:0]      i_data,
    output logic [31:0]      o_data,
    output logic             o_irq
);

    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] clr;
    logic [WIDTH-1:0] edge_q;
    logic [WIDTH-1:0] edge_d;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] mask_d;
    logic [31:0]      data_q;
    logic [31:0]      data_d;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_debounce (
            .clk     (clk),
            .reset   (reset),
            .i_raw   (i_switch[i]),
            .o_stable(stable[i]),
            .o_rise  (rise[i])
        );
    end

    if (WIDTH < 32) begin : g_unused_hi
        logic unused_data_hi;
        assign unused_data_hi = ^i_data[31:WIDTH];
    end

    // Clearing only the bits being returned lets a rise landing on the same
    // edge survive the read.
    always_comb begin
        clr    = '0;
        data_d = data_q;
        mask_d = mask_q;
        if (i_rd_en) begin
            case (i_addr)
                SW_ADDR_STATE: data_d = 32'(stable);
                SW_ADDR_EDGE: begin
                    data_d = 32'(edge_q);
                    clr    = edge_q;
                end
                SW_ADDR_MASK:  data_d = 32'(mask_q);
                default:       data_d = 32'h0;
            endcase
        end
        if (i_wr_en && i_addr == SW_ADDR_MASK) begin
            mask_d = i_data[WIDTH-1:0];
        end
        edge_d = (edge_q & ~clr) | rise;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            edge_q <= '0;
            mask_q <= '0;
            data_q <= 32'h0;
        end else begin
            edge_q <= edge_d;
            mask_q <= mask_d;
            data_q <= data_d;
        end
    end

    assign o_data = data_q;
    assign o_irq  = |(edge_q & mask_q);

endmodule

// File: doc/switch_reader.md
Name: switch_reader

Overview:
Memory-mapped input peripheral that samples the board's slide switches / push buttons for the CPU, the read-side counterpart of the LED output register.
- Synchronises and debounces each raw input bit.
- Captures rising edges into a sticky, read-to-clear register.
- Raises a maskable interrupt request.
- Sits on the peripheral bus next to the LED block; the CPU reads it with load instructions.

Parameters:
WIDTH, 8, number of switch/button inputs (1..32)
DEBOUNCE_CYCLES, 1000000, consecutive cycles a synchronised input must differ from the debounced value before the debounced value updates (>=2)
CNT_W, 20, width of each per-bit debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
i_switch  input  WIDTH  raw, asynchronous switch/button levels
i_rd_en  input  1  bus read strobe, one cycle per access
i_wr_en  input  1  bus write strobe, one cycle per access
i_addr  input  2  register select: 0 = STATE, 1 = EDGE, 2 = MASK, 3 = reserved
i_data  input  32  write data; only bits [WIDTH-1:0] are used
o_data  output  32  registered read data; upper bits above WIDTH are 0
o_irq  output  1  interrupt request, level, active-high

Behaviour:
- Reset (asynchronous): all state cleared.
  - Synchroniser flops, debounce counters, stable, edge, and mask all 0.
  - o_data = 32'h0, o_irq = 0.
- Synchroniser: two flops per bit; sync = i_switch delayed 2 cycles.
- Debounce, per bit, counter cnt:
  - sync == stable: cnt <= 0.
  - sync != stable and cnt == DEBOUNCE_CYCLES-1: stable <= sync, cnt <= 0.
  - Otherwise: cnt <= cnt+1.
  - Net effect: stable follows sync after exactly DEBOUNCE_CYCLES consecutive differing cycles.
  - Total latency from a raw edge to stable is 2 + DEBOUNCE_CYCLES cycles.
  - A pulse shorter than DEBOUNCE_CYCLES (post-sync) never reaches stable; its counter returns to 0.
- Rise detect: rise[i] = 1 for one cycle when stable[i] goes 0->1. Falls are not captured.
- EDGE register:
  - edge_next = (edge & ~clr) | rise.
  - clr = edge (the value being returned) when i_rd_en && i_addr == 1, else 0.
  - A rise in the same cycle as a clearing read is kept: set wins for newly arriving bits.
- MASK register: written when i_wr_en && i_addr == 2; mask <= i_data[WIDTH-1:0]. Writes to any other address are ignored.
- Read path, registered, 1-cycle latency:
  - On a cycle with i_rd_en, o_data on the next cycle holds, zero-extended:
    - addr 0: stable
    - addr 1: edge, pre-clear value
    - addr 2: mask
    - addr 3: 0
  - Without i_rd_en, o_data holds its previous value.
- o_irq = |(edge & mask), driven from registered state with no combinational path from inputs.
  - Deasserts the cycle after a clearing read unless a new masked rise arrived.
- Simultaneous read and write on the same cycle: both take effect; a read of MASK returns the old mask.
- Reset mid-debounce: counters are discarded, stable returns to 0, no edge is generated.
  - If the switch is held high through reset, a rise is detected 2 + DEBOUNCE_CYCLES cycles after reset falls.

Decomposition:
- Shared peripheral package holds:
  - Register address constants: SW_ADDR_STATE = 2'd0, SW_ADDR_EDGE = 2'd1, SW_ADDR_MASK = 2'd2.
  - Default DEBOUNCE_CYCLES for the board clock.
- One sub-module, debounce_bit: synchroniser, counter, and stable flop for a single input, with parameters DEBOUNCE_CYCLES and CNT_W.
  - Outputs stable and rise.
  - Instantiated WIDTH times by a generate loop.
- Edge, mask, and read mux live in the top.

Test Plan (bench uses WIDTH=8, DEBOUNCE_CYCLES=4, CNT_W=3):
1. Reset checks: hold reset with i_switch = 8'hFF, then release.
   - During reset: o_data = 0, o_irq = 0.
   - STATE read returns 8'hFF only from cycle 6 after release.
2. Glitch rejection: i_switch[0] high for 3 cycles, then low.
   - STATE stays 0, EDGE stays 0, o_irq stays 0.
3. Clean press with interrupt: write MASK = 8'h01, then hold i_switch[0] high.
   - stable[0] rises exactly 6 cycles after the raw edge; EDGE = 8'h01.
   - o_irq = 1 the cycle after the edge bit sets.
   - EDGE read returns 32'h1; o_irq drops the following cycle; a second EDGE read returns 0.
4. Read-clear collision: EDGE = 8'h01 and a debounced rise of bit 3 lands on the same cycle as an EDGE read.
   - Read returns 32'h01; the next EDGE read returns 32'h08.
5. Masking: rise on bit 2 with MASK = 8'h01.
   - EDGE = 8'h04 and o_irq stays 0.
   - Writing MASK = 8'h04 asserts o_irq next cycle.
6. Reset mid-debounce: assert reset 2 cycles into a debounce of bit 5.
   - After release with bit 5 held high: no edge earlier than cycle 6.
   - Edge bit 5 sets at cycle 6, and exactly once.
